// File: rtl/rotr_arbiter_if.sv
// rotr_arbiter_if: requester A/B and result valid/ready bundle.
// master drives requests and consumes results; slave is the arbiter.
interface rotr_arbiter_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic [SHW-1:0]   a_amt;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [SHW-1:0]   b_amt;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;

  modport master (
    output a_valid,
    output a_data,
    output a_amt,
    input  a_ready,
    output b_valid,
    output b_data,
    output b_amt,
    input  b_ready,
    input  res_valid,
    input  res_data,
    input  res_id,
    output res_ready
  );

  modport slave (
    input  a_valid,
    input  a_data,
    input  a_amt,
    output a_ready,
    input  b_valid,
    input  b_data,
    input  b_amt,
    output b_ready,
    output res_valid,
    output res_data,
    output res_id,
    input  res_ready
  );
endinterface

// File: rtl/rotr_arbiter.sv
// rotr_arbiter: round-robin share of one right-rotate unit by two requesters.
// Define ROTR_ARB_CNT_EN to add 8-bit accept counters cnt_a/cnt_b.
module rotr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rotr_arbiter_if.slave bus
`ifdef ROTR_ARB_CNT_EN
  ,
  output logic [7:0]    cnt_a,
  output logic [7:0]    cnt_b
`endif
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic             last_gnt;
  logic             gnt_a;
  logic             gnt_b;
  logic             can_load;
  logic             load_a;
  logic             load_b;
  logic             load;
  logic             sel_id;
  logic [WIDTH-1:0] sel_data;
  logic [SHW-1:0]   sel_amt;
  logic [WIDTH-1:0] rot_data;
  logic [0:0]       state;
  logic [0:0]       state_nxt;

  function automatic logic [WIDTH-1:0] rotr(
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   k
  );
    logic [2*WIDTH-1:0] dd;
    dd = {d, d} >> k;
    return dd[WIDTH-1:0];
  endfunction

  // Buffer occupancy is the FSM state.
  assign state = bus.res_valid;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    unique case (1'b1)
      bus.a_valid && !bus.b_valid: gnt_a = 1'b1;
      !bus.a_valid && bus.b_valid: gnt_b = 1'b1;
      bus.a_valid && bus.b_valid: begin
        gnt_a = last_gnt;
        gnt_b = !last_gnt;
      end
      default: ;
    endcase
  end

  assign can_load = !bus.res_valid || bus.res_ready;

  assign bus.a_ready = can_load && gnt_a && rst_n;
  assign bus.b_ready = can_load && gnt_b && rst_n;

  assign load_a = bus.a_ready && bus.a_valid;
  assign load_b = bus.b_ready && bus.b_valid;
  assign load   = load_a || load_b;

  assign sel_id   = load_b;
  assign sel_data = load_b ? bus.b_data : bus.a_data;
  assign sel_amt  = load_b ? bus.b_amt : bus.a_amt;
  assign rot_data = rotr(sel_data, sel_amt);

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (load) state_nxt = FULL;
      end
      FULL: begin
        if (load)
          state_nxt = FULL;
        else if (bus.res_ready)
          state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // last_gnt resets to B so A wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_id    <= 1'b0;
      last_gnt      <= 1'b1;
    end else begin
      bus.res_valid <= state_nxt;
      if (load) begin
        bus.res_data <= rot_data;
        bus.res_id   <= sel_id;
        last_gnt     <= sel_id;
      end
    end
  end

`ifdef ROTR_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a <= 8'd0;
      cnt_b <= 8'd0;
    end else begin
      if (load_a) cnt_a <= cnt_a + 8'd1;
      if (load_b) cnt_b <= cnt_b + 8'd1;
    end
  end
`endif

endmodule
